hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage WISC core, sitting between decode (IF/ID) and the
//  ID/EX, EX/MEM registers. Detects load-use, flag-to-branch and register-to-BR hazards and produces stall/bubble.
//  Adds a taken-branch flush sequencer, a data-memory-busy freeze, saturating stall counters and a stall watchdog.
// PARAMETERS
//  REG_W        4      register-specifier width (16 regs; R0 hardwired zero)
//  OPC_W        4      opcode width
//  FLAG_W       3      flag-enable width (Z,V,N)
//  OPC_B        4'hC   opcode of PC-relative conditional branch B
//  OPC_BR       4'hD   opcode of register branch BR
//  FLUSH_CYC    1      IF/ID flush cycles per taken branch (1..7)
//  CNT_W        16     width of stall_cnt / flush_cnt
//  WDOG_MAX     64     consecutive stall cycles before wdog_err sets (>=2)
// PORTS
//  clk            in   1       core clock, rising edge
//  rst            in   1       synchronous active-high reset
//  idex_memread   in   1       ID/EX instruction is a load
//  idex_regwrite  in   1       ID/EX instruction writes idex_rd
//  exmem_regwrite in   1       EX/MEM instruction writes exmem_rd
//  idex_flag_en   in   FLAG_W  flags written by ID/EX instruction
//  ifid_opcode    in   OPC_W   opcode in IF/ID
//  ifid_rs        in   REG_W   source 1 in IF/ID
//  ifid_rt        in   REG_W   source 2 in IF/ID
//  ifid_uses_rt   in   1       IF/ID instruction reads rt
//  idex_rd        in   REG_W   destination in ID/EX
//  exmem_rd       in   REG_W   destination in EX/MEM
//  condition      in   3       branch condition field of IF/ID (3'b111 = unconditional)
//  branch_taken   in   1       branch resolved taken this cycle
//  mem_busy       in   1       data memory not ready; pipeline must freeze
//  pc_write_en    out  1       1 = PC may update
//  ifid_write_en  out  1       1 = IF/ID may load
//  idex_bubble    out  1       1 = load NOP controls into ID/EX
//  pipe_freeze    out  1       1 = hold ID/EX, EX/MEM, MEM/WB
//  ifid_flush     out  1       1 = IF/ID loads NOP on this edge
//  stall_cnt      out  CNT_W   hazard-stall cycles since reset, saturating
//  flush_cnt      out  CNT_W   flush cycles since reset, saturating
//  wdog_err       out  1       sticky: hazard stall persisted WDOG_MAX cycles
// BEHAVIOUR
//  Hazard terms (combinational; rd==0 never matches):
//   lu  = idex_memread & idex_regwrite & (idex_rd==ifid_rs | ifid_uses_rt & idex_rd==ifid_rt)
//   fb  = opcode==OPC_B & |idex_flag_en & condition!=3'b111
//   rbr = opcode==OPC_BR & (|idex_flag_en & condition!=3'b111 | idex_regwrite & idex_rd==ifid_rs
//         | exmem_regwrite & exmem_rd==ifid_rs)     (register match on BR stalls even if unconditional)
//   haz = lu|fb|rbr
//  FSM states RUN, FLUSH, FREEZE; registered flush_left (3b).
//  Priority in any state: mem_busy > branch_taken/flush > haz.
//   FREEZE (or mem_busy=1 in any state): pc_write_en=0, ifid_write_en=0, pipe_freeze=1, idex_bubble=0,
//    ifid_flush=0. Leave when mem_busy=0: to FLUSH if flush_left!=0 else RUN. flush_left held.
//   RUN, branch_taken=1: ifid_flush=1, pc_write_en=1, haz ignored; if FLUSH_CYC>1 go FLUSH with
//    flush_left=FLUSH_CYC-1.
//   FLUSH: ifid_flush=1, pc_write_en=1, flush_left decrements each non-frozen cycle; ->RUN at 1.
//    branch_taken in FLUSH reloads flush_left=FLUSH_CYC-1.
//   RUN, haz=1 (no busy/taken): pc_write_en=0, ifid_write_en=0, idex_bubble=1 same cycle (no latency).
//   Else all enables 1, bubble/freeze/flush 0.
//  Counters: stall_cnt +1 per cycle idex_bubble=1; flush_cnt +1 per cycle ifid_flush=1; both hold at max.
//  Watchdog: run counter +1 per consecutive idex_bubble cycle, cleared otherwise; reaching WDOG_MAX
//   sets wdog_err, cleared only by rst.
//  Reset (rst=1 at edge): state RUN, flush_left 0, counters 0, wdog_err 0. While rst=1, outputs forced:
//   pc_write_en=0, ifid_write_en=0, idex_bubble=1, pipe_freeze=0, ifid_flush=0. Reset mid-FLUSH/FREEZE
//   aborts the sequence.
// TESTING
//  1 Load-use: idex_memread=1, idex_regwrite=1, idex_rd=3, ifid_rs=3 -> same cycle pc_write_en=0,
//    idex_bubble=1; stall_cnt 0->1.
//  2 R0/unconditional: idex_rd=0=ifid_rs with load -> no stall; OPC_B, flag_en=3'b111, cond=3'b111 -> no stall.
//  3 BR dep: opcode 4'hD, ifid_rs=5, exmem_regwrite=1, exmem_rd=5 -> stall one cycle.
//  4 FLUSH_CYC=3, branch_taken=1 one cycle -> ifid_flush=1 for exactly 3 cycles, flush_cnt=3; concurrent haz
//    ignored.
//  5 mem_busy=1 for 4 cycles during FLUSH (flush_left=1) -> freeze 4 cycles, then 1 flush cycle, RUN.
//  6 WDOG_MAX=4, haz held 4 cycles -> wdog_err=1 after 4th edge, stays 1 after haz drops; rst clears all.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Purpose : pipeline hazard controller (load-use, flag->branch, reg->BR) with branch flush, mem-busy freeze, stats, watchdog.
// Latency : stall/bubble/flush/freeze are combinational in the same cycle; counters and wdog_err update on the next edge.
// Backpr. : mem_busy freezes the whole pipe and takes priority over flush and hazard stalls; flush sequence resumes afterwards.
module hazard_stall_ctrl #(
  parameter int                REG_W     = 4,
  parameter int                OPC_W     = 4,
  parameter int                FLAG_W    = 3,
  parameter logic [OPC_W-1:0]  OPC_B     = 4'hC,
  parameter logic [OPC_W-1:0]  OPC_BR    = 4'hD,
  parameter int                FLUSH_CYC = 1,
  parameter int                CNT_W     = 16,
  parameter int                WDOG_MAX  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idex_memread,
  input  logic              idex_regwrite,
  input  logic              exmem_regwrite,
  input  logic [FLAG_W-1:0] idex_flag_en,
  input  logic [OPC_W-1:0]  ifid_opcode,
  input  logic [REG_W-1:0]  ifid_rs,
  input  logic [REG_W-1:0]  ifid_rt,
  input  logic              ifid_uses_rt,
  input  logic [REG_W-1:0]  idex_rd,
  input  logic [REG_W-1:0]  exmem_rd,
  input  logic [2:0]        condition,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              pc_write_en,
  output logic              ifid_write_en,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              ifid_flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              wdog_err
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYC - 1);
  localparam int         WD_W      = $clog2(WDOG_MAX + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_MAX - 1);

  state_t          state, state_nxt, eff_state;
  logic [2:0]      flush_left, flush_left_nxt;
  logic [WD_W-1:0] run_cnt;
  logic            lu, fb, rbr, haz, cond_uncond;

  // Hazard detection; R0 is hardwired zero so rd==0 never creates a dependency
  always_comb begin
    cond_uncond = (condition == 3'b111);
    lu  = idex_memread & idex_regwrite & (idex_rd != '0) &
          ((idex_rd == ifid_rs) | (ifid_uses_rt & (idex_rd == ifid_rt)));
    fb  = (ifid_opcode == OPC_B) & (|idex_flag_en) & ~cond_uncond;
    rbr = (ifid_opcode == OPC_BR) &
          (((|idex_flag_en) & ~cond_uncond) |
           (idex_regwrite  & (idex_rd  != '0) & (idex_rd  == ifid_rs)) |
           (exmem_regwrite & (exmem_rd != '0) & (exmem_rd == ifid_rs)));
    haz = lu | fb | rbr;
  end

  // Next-state and pipeline control; FREEZE with busy dropped behaves as the state it resumes into
  always_comb begin
    pc_write_en    = 1'b1;
    ifid_write_en  = 1'b1;
    idex_bubble    = 1'b0;
    pipe_freeze    = 1'b0;
    ifid_flush     = 1'b0;
    state_nxt      = state;
    flush_left_nxt = flush_left;
    eff_state      = state;

    if (state == FREEZE) begin
      eff_state = (flush_left != 3'd0) ? FLUSH : RUN;
    end

    if (rst) begin
      pc_write_en    = 1'b0;
      ifid_write_en  = 1'b0;
      idex_bubble    = 1'b1;
      state_nxt      = RUN;
      flush_left_nxt = 3'd0;
    end else if (mem_busy) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      pipe_freeze   = 1'b1;
      state_nxt     = FREEZE;
    end else if (eff_state == FLUSH) begin
      ifid_flush = 1'b1;
      if (branch_taken) begin
        flush_left_nxt = FL_RELOAD;
        state_nxt      = (FL_RELOAD != 3'd0) ? FLUSH : RUN;
      end else if (flush_left <= 3'd1) begin
        flush_left_nxt = 3'd0;
        state_nxt      = RUN;
      end else begin
        flush_left_nxt = flush_left - 3'd1;
        state_nxt      = FLUSH;
      end
    end else if (branch_taken) begin
      ifid_flush     = 1'b1;
      flush_left_nxt = FL_RELOAD;
      state_nxt      = (FL_RELOAD != 3'd0) ? FLUSH : RUN;
    end else if (haz) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      idex_bubble   = 1'b1;
      state_nxt     = RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  // State and flush-sequence registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= 3'd0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
    end
  end

  // Saturating stall/flush statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (idex_bubble && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (ifid_flush  && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Watchdog: counts consecutive bubble cycles, latches wdog_err on the WDOG_MAX-th one
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= '0;
      wdog_err <= 1'b0;
    end else if (idex_bubble) begin
      if (run_cnt == WD_LAST) begin
        wdog_err <= 1'b1;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end else begin
      run_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with FLUSH_CYC=3 and WDOG_MAX=4.
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        idex_memread, idex_regwrite, exmem_regwrite;
  logic [2:0]  idex_flag_en;
  logic [3:0]  ifid_opcode, ifid_rs, ifid_rt, idex_rd, exmem_rd;
  logic        ifid_uses_rt;
  logic [2:0]  condition;
  logic        branch_taken, mem_busy;
  logic        pc_write_en, ifid_write_en, idex_bubble, pipe_freeze, ifid_flush;
  logic [15:0] stall_cnt, flush_cnt;
  logic        wdog_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .FLUSH_CYC (3),
    .CNT_W     (16),
    .WDOG_MAX  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .idex_memread   (idex_memread),
    .idex_regwrite  (idex_regwrite),
    .exmem_regwrite (exmem_regwrite),
    .idex_flag_en   (idex_flag_en),
    .ifid_opcode    (ifid_opcode),
    .ifid_rs        (ifid_rs),
    .ifid_rt        (ifid_rt),
    .ifid_uses_rt   (ifid_uses_rt),
    .idex_rd        (idex_rd),
    .exmem_rd       (exmem_rd),
    .condition      (condition),
    .branch_taken   (branch_taken),
    .mem_busy       (mem_busy),
    .pc_write_en    (pc_write_en),
    .ifid_write_en  (ifid_write_en),
    .idex_bubble    (idex_bubble),
    .pipe_freeze    (pipe_freeze),
    .ifid_flush     (ifid_flush),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .wdog_err       (wdog_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_memread   = 1'b0;
    idex_regwrite  = 1'b0;
    exmem_regwrite = 1'b0;
    idex_flag_en   = 3'b000;
    ifid_opcode    = 4'h0;
    ifid_rs        = 4'h0;
    ifid_rt        = 4'h0;
    ifid_uses_rt   = 1'b0;
    idex_rd        = 4'h0;
    exmem_rd       = 4'h0;
    condition      = 3'b111;
    branch_taken   = 1'b0;
    mem_busy       = 1'b0;
  endtask

  task automatic load_use_on();
    idex_memread  = 1'b1;
    idex_regwrite = 1'b1;
    idex_rd       = 4'd3;
    ifid_rs       = 4'd3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
  endtask

  initial begin
    do_reset();
    // Reset: forced outputs and cleared state
    chk("rst_pc_we",  {31'd0, pc_write_en},   32'd0);
    chk("rst_ifid_we",{31'd0, ifid_write_en}, 32'd0);
    chk("rst_bubble", {31'd0, idex_bubble},   32'd1);
    chk("rst_freeze", {31'd0, pipe_freeze},   32'd0);
    chk("rst_flush",  {31'd0, ifid_flush},    32'd0);
    chk("rst_stall",  {16'd0, stall_cnt},     32'd0);
    chk("rst_fcnt",   {16'd0, flush_cnt},     32'd0);
    chk("rst_wdog",   {31'd0, wdog_err},      32'd0);
    rst = 1'b0;
    #1;
    chk("idle_pc_we",  {31'd0, pc_write_en}, 32'd1);
    chk("idle_bubble", {31'd0, idex_bubble}, 32'd0);

    // 1: load-use stalls in the same cycle
    load_use_on();
    #1;
    chk("lu_pc_we",   {31'd0, pc_write_en},   32'd0);
    chk("lu_ifid_we", {31'd0, ifid_write_en}, 32'd0);
    chk("lu_bubble",  {31'd0, idex_bubble},   32'd1);
    chk("lu_stall0",  {16'd0, stall_cnt},     32'd0);
    tick();
    idle();
    #1;
    chk("lu_stall1",  {16'd0, stall_cnt},     32'd1);
    chk("lu_release", {31'd0, idex_bubble},   32'd0);

    // Load-use via rt only when rt is actually read
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 4'd7; ifid_rs = 4'd2; ifid_rt = 4'd7;
    #1;
    chk("lu_rt_unused", {31'd0, idex_bubble}, 32'd0);
    ifid_uses_rt = 1'b1;
    #1;
    chk("lu_rt_used",   {31'd0, idex_bubble}, 32'd1);
    idle();

    // 2: R0 never matches; unconditional B never waits on flags
    idex_memread = 1'b1; idex_regwrite = 1'b1; idex_rd = 4'd0; ifid_rs = 4'd0;
    #1;
    chk("r0_no_stall", {31'd0, idex_bubble}, 32'd0);
    idle();
    ifid_opcode = 4'hC; idex_flag_en = 3'b111; condition = 3'b111;
    #1;
    chk("b_uncond", {31'd0, idex_bubble}, 32'd0);
    condition = 3'b000;
    #1;
    chk("b_cond_flag", {31'd0, idex_bubble}, 32'd1);
    idle();
    #1;

    // 3: BR depends on EX/MEM destination, stalls one cycle
    ifid_opcode = 4'hD; ifid_rs = 4'd5; exmem_regwrite = 1'b1; exmem_rd = 4'd5; condition = 3'b111;
    #1;
    chk("br_dep_bubble", {31'd0, idex_bubble}, 32'd1);
    chk("br_dep_pc_we",  {31'd0, pc_write_en}, 32'd0);
    tick();
    idle();
    #1;
    chk("br_dep_stall", {16'd0, stall_cnt}, 32'd2);

    // 4: taken branch flushes 3 cycles and overrides a concurrent hazard
    branch_taken = 1'b1;
    load_use_on();
    #1;
    chk("fl0_flush",  {31'd0, ifid_flush},  32'd1);
    chk("fl0_bubble", {31'd0, idex_bubble}, 32'd0);
    chk("fl0_pc_we",  {31'd0, pc_write_en}, 32'd1);
    tick();
    branch_taken = 1'b0;
    #1;
    chk("fl1_flush",  {31'd0, ifid_flush},  32'd1);
    chk("fl1_bubble", {31'd0, idex_bubble}, 32'd0);
    tick();
    #1;
    chk("fl2_flush",  {31'd0, ifid_flush},  32'd1);
    tick();
    idle();
    #1;
    chk("fl3_flush",  {31'd0, ifid_flush},  32'd0);
    chk("fl_cnt3",    {16'd0, flush_cnt},   32'd3);
    chk("fl_stall",   {16'd0, stall_cnt},   32'd2);

    // 5: freeze for 4 cycles with one flush cycle pending
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("frz_freeze", {31'd0, pipe_freeze}, 32'd1);
      chk("frz_flush",  {31'd0, ifid_flush},  32'd0);
      chk("frz_pc_we",  {31'd0, pc_write_en}, 32'd0);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    chk("frz_resume_flush",  {31'd0, ifid_flush},  32'd1);
    chk("frz_resume_freeze", {31'd0, pipe_freeze}, 32'd0);
    tick();
    #1;
    chk("frz_run_flush", {31'd0, ifid_flush},  32'd0);
    chk("frz_run_pc_we", {31'd0, pc_write_en}, 32'd1);
    chk("frz_fcnt",      {16'd0, flush_cnt},   32'd6);

    // 6: watchdog after 4 consecutive stalls, sticky until reset
    do_reset();
    rst = 1'b0;
    load_use_on();
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("wd_pre", {31'd0, wdog_err}, 32'd0);
    end
    tick();
    chk("wd_set", {31'd0, wdog_err}, 32'd1);
    idle();
    tick();
    chk("wd_sticky", {31'd0, wdog_err},  32'd1);
    chk("wd_stall",  {16'd0, stall_cnt}, 32'd4);
    do_reset();
    chk("wd_rst_err",   {31'd0, wdog_err},  32'd0);
    chk("wd_rst_stall", {16'd0, stall_cnt}, 32'd0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
